div_operand_sequencer: RTL and testbench

Upstream front-end for the `longDivision` datapath. It accepts a byte stream over a valid/ready handshake and pairs the bytes as dividend then divisor. It launches one division per pair on the divider's start/busy/done interface and returns quotient and remainder to a downstream consumer over a second valid/ready handshake. Divide-by-zero is resolved locally and never reaches the divider.

---
 rtl/div_operand_sequencer.sv | 152 +++++++++++++++
 tb/tb_div_operand_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div_operand_sequencer.sv
// Byte-stream front-end for the long-division datapath: pairs dividend/divisor bytes,
// launches the divider, resolves divide-by-zero locally and hands results downstream.
module div_operand_sequencer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_start,
    output logic [DATA_WIDTH-1:0] o_dividend,
    output logic [DATA_WIDTH-1:0] o_divisor,
    input  logic                  i_busy,
    input  logic                  i_done,
    input  logic [DATA_WIDTH-1:0] i_quotient,
    input  logic [DATA_WIDTH-1:0] i_remainder,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_quotient,
    output logic [DATA_WIDTH-1:0] o_remainder,
    output logic                  o_div_by_zero,
    output logic [7:0]            o_op_count
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_DIVIDEND,
        S_DIVISOR,
        S_ISSUE,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic divisor_zero;
    logic ld_dividend;
    logic ld_divisor;
    logic ld_zero;
    logic ld_result;
    logic cnt_inc;

    assign divisor_zero = (i_data == '0);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_DIVIDEND;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshake decode and load enables
    always_comb begin
        state_d     = state_q;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        o_start     = 1'b0;
        ld_dividend = 1'b0;
        ld_divisor  = 1'b0;
        ld_zero     = 1'b0;
        ld_result   = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            S_DIVIDEND: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    ld_dividend = 1'b1;
                    state_d     = S_DIVISOR;
                end
            end
            S_DIVISOR: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    if (divisor_zero) begin
                        ld_zero = 1'b1;
                        state_d = S_RESULT;
                    end else begin
                        ld_divisor = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                o_start = !i_busy;
                if (!i_busy) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_done) begin
                    ld_result = 1'b1;
                    state_d   = S_RESULT;
                end
            end
            S_RESULT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    cnt_inc = 1'b1;
                    state_d = S_DIVIDEND;
                end
            end
            default: state_d = S_DIVIDEND;
        endcase
    end

    // Operand registers stay put between captures
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_dividend <= '0;
            o_divisor  <= '0;
        end else begin
            if (ld_dividend) begin
                o_dividend <= i_data;
            end
            if (ld_divisor) begin
                o_divisor <= i_data;
            end
        end
    end

    // Result registers: zero divisor yields all-ones quotient and the dividend as remainder
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else if (ld_zero) begin
            o_quotient    <= {DATA_WIDTH{1'b1}};
            o_remainder   <= o_dividend;
            o_div_by_zero <= 1'b1;
        end else if (ld_result) begin
            o_quotient    <= i_quotient;
            o_remainder   <= i_remainder;
            o_div_by_zero <= 1'b0;
        end
    end

    // Completed-result counter, wraps naturally
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_op_count <= '0;
        end else if (cnt_inc) begin
            o_op_count <= o_op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_div_operand_sequencer.sv
// Directed bench for div_operand_sequencer with a hand-driven divider model.
module tb_div_operand_sequencer;

    localparam int unsigned DW = 8;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_data = '0;
    logic          o_start;
    logic [DW-1:0] o_dividend;
    logic [DW-1:0] o_divisor;
    logic          i_busy = 1'b0;
    logic          i_done = 1'b0;
    logic [DW-1:0] i_quotient = '0;
    logic [DW-1:0] i_remainder = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_quotient;
    logic [DW-1:0] o_remainder;
    logic          o_div_by_zero;
    logic [7:0]    o_op_count;

    int         n_checks = 0;
    int         n_fail = 0;
    int         start_cnt = 0;
    logic [7:0] exp_cnt = '0;

    div_operand_sequencer #(.DATA_WIDTH(DW)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .o_start      (o_start),
        .o_dividend   (o_dividend),
        .o_divisor    (o_divisor),
        .i_busy       (i_busy),
        .i_done       (i_done),
        .i_quotient   (i_quotient),
        .i_remainder  (i_remainder),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero),
        .o_op_count   (o_op_count)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_start === 1'b1) start_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " ready"},    32'(o_ready), 1);
        check_eq({tag, " start"},    32'(o_start), 0);
        check_eq({tag, " valid"},    32'(o_valid), 0);
        check_eq({tag, " dbz"},      32'(o_div_by_zero), 0);
        check_eq({tag, " dividend"}, 32'(o_dividend), 0);
        check_eq({tag, " divisor"},  32'(o_divisor), 0);
        check_eq({tag, " quot"},     32'(o_quotient), 0);
        check_eq({tag, " rem"},      32'(o_remainder), 0);
        check_eq({tag, " count"},    32'(o_op_count), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_data  = b;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, " in ready"}, 32'(o_ready), 1);
        tick();
        i_valid = 1'b0;
        i_data  = '0;
    endtask

    // One full operation; divider answers with model values lat cycles after start
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int busy_cyc,
                          input int lat, input int hold, input logic [7:0] eq,
                          input logic [7:0] er, input logic edbz, input string tag);
        int s0;
        s0 = start_cnt;
        send_byte(a, tag);
        i_busy = (busy_cyc > 0);
        send_byte(b, tag);
        if (b != 8'd0) begin
            check_eq({tag, " issue ready"}, 32'(o_ready), 0);
            check_eq({tag, " dividend"}, 32'(o_dividend), 32'(a));
            check_eq({tag, " divisor"}, 32'(o_divisor), 32'(b));
            for (int i = 0; i < busy_cyc; i++) begin
                check_eq({tag, " busy start"}, 32'(o_start), 0);
                tick();
            end
            i_busy = 1'b0;
            #1;
            check_eq({tag, " start"}, 32'(o_start), 1);
            tick();
            check_eq({tag, " start low"}, 32'(o_start), 0);
            for (int i = 1; i < lat; i++) begin
                check_eq({tag, " wait valid"}, 32'(o_valid), 0);
                tick();
            end
            i_quotient  = a / b;
            i_remainder = a % b;
            i_done      = 1'b1;
            tick();
            i_done      = 1'b0;
            i_quotient  = '0;
            i_remainder = '0;
        end
        check_eq({tag, " valid"}, 32'(o_valid), 1);
        check_eq({tag, " quot"}, 32'(o_quotient), 32'(eq));
        check_eq({tag, " rem"}, 32'(o_remainder), 32'(er));
        check_eq({tag, " dbz"}, 32'(o_div_by_zero), 32'(edbz));
        check_eq({tag, " res ready"}, 32'(o_ready), 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq({tag, " hold valid"}, 32'(o_valid), 1);
            check_eq({tag, " hold quot"}, 32'(o_quotient), 32'(eq));
            check_eq({tag, " hold rem"}, 32'(o_remainder), 32'(er));
            check_eq({tag, " hold ready"}, 32'(o_ready), 0);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check_eq({tag, " post valid"}, 32'(o_valid), 0);
        check_eq({tag, " post ready"}, 32'(o_ready), 1);
        check_eq({tag, " count"}, 32'(o_op_count), 32'(exp_cnt));
        check_eq({tag, " starts"}, 32'(start_cnt - s0), (b != 8'd0) ? 1 : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check_reset_vals("reset");
        i_reset_n = 1'b1;
        tick();
        check_reset_vals("post reset");

        run_op(8'd200, 8'd7,   0, 3, 0, 8'd28,  8'd4,  1'b0, "normal");
        run_op(8'd55,  8'd0,   0, 1, 0, 8'd255, 8'd55, 1'b1, "dbz");
        run_op(8'd100, 8'd7,   0, 2, 5, 8'd14,  8'd2,  1'b0, "backpressure");
        run_op(8'd50,  8'd6,   4, 2, 0, 8'd8,   8'd2,  1'b0, "busy");
        run_op(8'd0,   8'd255, 0, 1, 0, 8'd0,   8'd0,  1'b0, "zero dividend");

        // Reset while the divider is working, then a stale done
        send_byte(8'd100, "midreset");
        send_byte(8'd10, "midreset");
        tick();
        i_reset_n = 1'b0;
        #1;
        check_reset_vals("midreset async");
        tick();
        i_reset_n = 1'b1;
        exp_cnt = '0;
        tick();
        i_quotient  = 8'd10;
        i_remainder = 8'd0;
        i_done      = 1'b1;
        tick();
        i_done      = 1'b0;
        check_eq("late done valid", 32'(o_valid), 0);
        check_eq("late done ready", 32'(o_ready), 1);
        check_eq("late done quot", 32'(o_quotient), 0);
        tick();
        check_eq("late done valid2", 32'(o_valid), 0);

        for (int k = 0; k < 256; k++) begin
            run_op(8'd9, 8'd3, 0, 1, 0, 8'd3, 8'd0, 1'b0, "wrap");
        end
        check_eq("wrap count", 32'(o_op_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
